// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve/play/pause/point/over control, paddle-miss
// detection, saturating scores and winner declaration, paced by frame_tick.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int PADDLE_H     = 64,
  parameter int WALL_L       = 14,
  parameter int WALL_R       = 626
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic [5:0] ball_w,
  input  logic [8:0] paddle_l_y,
  input  logic [8:0] paddle_r_y,
  output logic       ball_rst,
  output logic       ball_step,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic       flash,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_POINT = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic        start_q;
  logic        start_rise;
  logic [7:0]  frame_cnt;
  logic [8:0]  frame_cnt_inc;
  logic        serve_done;
  logic        point_done;
  logic [10:0] ball_bot;
  logic [10:0] ball_right;
  logic        clear_l;
  logic        clear_r;
  logic        miss_l;
  logic        miss_r;
  logic [2:0]  state_d;
  logic [3:0]  score_l_d;
  logic [3:0]  score_r_d;
  logic [1:0]  winner_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  assign start_rise    = start & ~start_q;
  assign frame_cnt_inc = {1'b0, frame_cnt} + 9'd1;
  assign serve_done    = frame_tick && (frame_cnt_inc == 9'(SERVE_FRAMES));
  assign point_done    = frame_tick && (frame_cnt_inc == 9'(POINT_FRAMES));

  // The ball escapes a paddle when it lies entirely above or entirely below it.
  assign ball_bot   = 11'(ball_y) + 11'(ball_w);
  assign ball_right = 11'(ball_x) + 11'(ball_w);
  assign clear_l    = (ball_bot <= 11'(paddle_l_y)) ||
                      (11'(ball_y) >= 11'(paddle_l_y) + 11'(PADDLE_H));
  assign clear_r    = (ball_bot <= 11'(paddle_r_y)) ||
                      (11'(ball_y) >= 11'(paddle_r_y) + 11'(PADDLE_H));
  assign miss_l     = frame_tick && (11'(ball_x) < 11'(WALL_L)) && clear_l;
  assign miss_r     = frame_tick && (ball_right > 11'(WALL_R)) && clear_r;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d   = state;
    score_l_d = score_l;
    score_r_d = score_r;
    winner_d  = winner;
    case (state)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          state_d   = S_SERVE;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          winner_d  = 2'b00;
        end
      end
      S_SERVE: if (serve_done) state_d = S_PLAY;
      S_PLAY: begin
        // Left miss has priority; a miss outranks a pause request.
        if (miss_l) begin
          score_r_d = sat_inc(score_r);
          state_d   = S_POINT;
        end else if (miss_r) begin
          score_l_d = sat_inc(score_l);
          state_d   = S_POINT;
        end else if (start_rise) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: if (start_rise) state_d = S_PLAY;
      S_POINT: begin
        if (point_done) begin
          if (score_l == 4'(WIN_SCORE)) begin
            state_d  = S_OVER;
            winner_d = 2'b01;
          end else if (score_r == 4'(WIN_SCORE)) begin
            state_d  = S_OVER;
            winner_d = 2'b10;
          end else begin
            state_d = S_SERVE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      frame_cnt <= 8'd0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      winner    <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_d;
      start_q <= start;
      score_l <= score_l_d;
      score_r <= score_r_d;
      winner  <= winner_d;
      if (state_d != state) frame_cnt <= 8'd0;
      else if (frame_tick)  frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign ball_rst  = (state != S_PLAY) && (state != S_PAUSE);
  assign ball_step = (state == S_PLAY) && frame_tick;
  assign flash     = (state == S_POINT) ? frame_cnt[3] :
                     (state == S_OVER)  ? frame_cnt[4] : 1'b0;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a driver pushes model predictions per
// cycle, a monitor pops and compares them against the DUT outputs.
module tb_pong_game_ctrl;

  localparam int WIN    = 7;
  localparam int SERVE  = 60;
  localparam int POINT  = 90;
  localparam int PAD_H  = 64;
  localparam int WALL_L = 14;
  localparam int WALL_R = 626;

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSE = 3, M_POINT = 4, M_OVER = 5;

  typedef struct packed {
    logic [2:0] state;
    logic       ball_rst;
    logic       ball_step;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;
    logic       flash;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [5:0] ball_w;
  logic [8:0] paddle_l_y;
  logic [8:0] paddle_r_y;
  logic       ball_rst;
  logic       ball_step;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] winner;
  logic       flash;
  logic [2:0] state;

  pong_game_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT),
    .PADDLE_H(PAD_H), .WALL_L(WALL_L), .WALL_R(WALL_R)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .ball_w(ball_w),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_rst(ball_rst), .ball_step(ball_step), .score_l(score_l),
    .score_r(score_r), .winner(winner), .flash(flash), .state(state)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: match rules expressed as phase, ticks since entry, scores.
  int m_phase, m_ticks, m_sl, m_sr, m_win;
  bit m_prev_start;

  function automatic void model_reset();
    m_phase = M_IDLE; m_ticks = 0; m_sl = 0; m_sr = 0; m_win = 0; m_prev_start = 0;
  endfunction

  function automatic exp_t model_out(input bit ft);
    exp_t e;
    e.state     = 3'(m_phase);
    e.ball_rst  = !(m_phase == M_PLAY || m_phase == M_PAUSE);
    e.ball_step = (m_phase == M_PLAY) && ft;
    e.score_l   = 4'(m_sl);
    e.score_r   = 4'(m_sr);
    e.winner    = 2'(m_win);
    e.flash     = (m_phase == M_POINT) ? bit'((m_ticks / 8) % 2) :
                  (m_phase == M_OVER)  ? bit'((m_ticks / 16) % 2) : 1'b0;
    return e;
  endfunction

  function automatic bit escapes(input int by, input int bw, input int py);
    return (by + bw <= py) || (by >= py + PAD_H);
  endfunction

  function automatic void model_update(input bit ft, input bit st, input int bx, input int by,
                                       input int bw, input int ply, input int pry);
    bit rise = st && !m_prev_start;
    int nxt  = m_phase;
    case (m_phase)
      M_IDLE, M_OVER: if (rise) begin nxt = M_SERVE; m_sl = 0; m_sr = 0; m_win = 0; end
      M_SERVE: if (ft && m_ticks + 1 == SERVE) nxt = M_PLAY;
      M_PLAY: begin
        if (ft && bx < WALL_L && escapes(by, bw, ply)) begin
          m_sr = (m_sr < 15) ? m_sr + 1 : 15; nxt = M_POINT;
        end else if (ft && bx + bw > WALL_R && escapes(by, bw, pry)) begin
          m_sl = (m_sl < 15) ? m_sl + 1 : 15; nxt = M_POINT;
        end else if (rise) nxt = M_PAUSE;
      end
      M_PAUSE: if (rise) nxt = M_PLAY;
      M_POINT: if (ft && m_ticks + 1 == POINT) begin
        if (m_sl == WIN)      begin nxt = M_OVER; m_win = 1; end
        else if (m_sr == WIN) begin nxt = M_OVER; m_win = 2; end
        else nxt = M_SERVE;
      end
      default: nxt = M_IDLE;
    endcase
    if (nxt != m_phase) m_ticks = 0;
    else if (ft)        m_ticks = (m_ticks + 1) % 256;
    m_phase      = nxt;
    m_prev_start = st;
  endfunction

  // Driver: one call per clock cycle, inputs change just after the falling edge.
  task automatic step(input bit ft, input bit st, input int bx, input int by,
                      input int bw, input int ply, input int pry);
    @(negedge clk);
    #1;
    frame_tick = ft; start = st;
    ball_x = 10'(bx); ball_y = 9'(by); ball_w = 6'(bw);
    paddle_l_y = 9'(ply); paddle_r_y = 9'(pry);
    sb_q.push_back(model_out(ft));
    model_update(ft, st, bx, by, bw, ply, pry);
  endtask

  int bx = 300, by = 200, bw = 8, ply = 100, pry = 100;

  task automatic go(input bit ft, input bit st);
    step(ft, st, bx, by, bw, ply, pry);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) go(1'b0, 1'b0);
      go(1'b1, 1'b0);
    end
  endtask

  task automatic press();
    go(1'b0, 1'b1);
    go(1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset state", 32'(state), 0);
    check("reset ball_rst", 32'(ball_rst), 1);
    check("reset ball_step", 32'(ball_step), 0);
    check("reset score_l", 32'(score_l), 0);
    check("reset score_r", 32'(score_r), 0);
    check("reset winner", 32'(winner), 0);
    check("reset flash", 32'(flash), 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    start = 1'b0; frame_tick = 1'b0;
  endtask

  // Monitor: samples mid-cycle, after the driver has settled the inputs.
  initial begin
    int cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("state c%0d", cyc), 32'(state), 32'(e.state));
        check($sformatf("ball_rst c%0d", cyc), 32'(ball_rst), 32'(e.ball_rst));
        check($sformatf("ball_step c%0d", cyc), 32'(ball_step), 32'(e.ball_step));
        check($sformatf("score_l c%0d", cyc), 32'(score_l), 32'(e.score_l));
        check($sformatf("score_r c%0d", cyc), 32'(score_r), 32'(e.score_r));
        check($sformatf("winner c%0d", cyc), 32'(winner), 32'(e.winner));
        check($sformatf("flash c%0d", cyc), 32'(flash), 32'(e.flash));
      end
      cyc++;
    end
  end

  initial begin
    bit st;
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
    ball_x = '0; ball_y = '0; ball_w = '0; paddle_l_y = '0; paddle_r_y = '0;
    model_reset();
    async_reset();
    go(1'b0, 1'b0);

    // Serve then play with the ball in mid-field.
    by = $urandom_range(0, 400);
    press();
    ticks(SERVE);
    ticks(5);

    // Left miss, point interval, serve.
    bx = 10; by = 200; bw = 8; ply = 300;
    ticks(1);
    bx = 300;
    ticks(POINT);
    ticks(SERVE);

    // Paddle covers the ball: no score.
    bx = 10; ply = 180;
    ticks(3);
    bx = 300;

    // Pause and resume.
    press();
    ticks(5);
    press();
    ticks(2);

    // Right misses until the left player wins.
    for (int p = 0; p < WIN; p++) begin
      bx = 620; bw = 8; by = 200; pry = 0;
      ticks(1);
      bx = 300;
      ticks(POINT);
      if (p < WIN - 1) ticks(SERVE);
    end
    ticks(40);
    press();
    ticks(SERVE);

    // Miss and start rise on the same tick: the miss wins.
    bx = 10; ply = 300;
    go(1'b1, 1'b1);
    go(1'b0, 1'b0);
    bx = 300;
    ticks(POINT);
    ticks(SERVE);

    // Random play with a level-style start button.
    st = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) st = ~st;
      case ($urandom_range(0, 3))
        0: bx = $urandom_range(0, 20);
        1: bx = $urandom_range(560, 640);
        default: bx = $urandom_range(0, 1023);
      endcase
      by = $urandom_range(0, 511); bw = $urandom_range(0, 63);
      ply = $urandom_range(0, 511); pry = $urandom_range(0, 511);
      step($urandom_range(0, 2) == 0, st, bx, by, bw, ply, pry);
    end

    // Reach POINT with score_l=3, then reset mid-interval.
    async_reset();
    bx = 300; by = 200; bw = 8; pry = 0; ply = 100;
    press();
    ticks(SERVE);
    for (int p = 0; p < 3; p++) begin
      bx = 620;
      ticks(1);
      bx = 300;
      if (p < 2) begin ticks(POINT); ticks(SERVE); end
    end
    ticks(4);
    async_reset();
    go(1'b0, 1'b0);
    press();
    ticks(3);

    repeat (2) @(negedge clk);
    #5;
    check("scoreboard drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
